sram_arbiter: RTL
=================

# sram_arbiter

Two-client arbiter that shares one single-port synchronous SRAM (active-low nCS/nOE/nWE control, 1-cycle registered read data) between two independent requesters, such as a FIFO controller and a debug/host port. Each client uses a valid/grant handshake. The arbiter serialises accepted commands onto the SRAM port with round-robin fairness and returns read data with a per-client valid pulse. It sits between the clients and the SRAM macro, replacing a direct controller-to-SRAM connection.

## Interface
- ADDR_SIZE, 6, SRAM address width
- DATA_SIZE, 16, SRAM data width

- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- Req0 / Req1  in  1  client command valid
- We0 / We1  in  1  1 = write, 0 = read; qualified by ReqN
- Addr0 / Addr1  in  ADDR_SIZE  client address
- WData0 / WData1  in  DATA_SIZE  client write data
- Gnt0 / Gnt1  out  1  combinational grant; transfer occurs on the edge where ReqN & GntN
- RValid0 / RValid1  out  1  one-cycle pulse: RDataOut holds this client's read data
- RDataOut  out  DATA_SIZE  shared read-data return; equals RData
- Addr  out  ADDR_SIZE  SRAM address, registered
- WData  out  DATA_SIZE  SRAM write data, registered
- RData  in  DATA_SIZE  SRAM read data; valid the cycle after the SRAM samples a read
- nCS / nOE / nWE  out  1  SRAM controls, active-low, registered

## Operation
- Grant logic is combinational on Req0, Req1 and the round-robin pointer `last`:
  - Only one client requesting: that client is granted.
  - Both requesting: the client not equal to `last` is granted.
  - Neither requesting: no grant.
  - Gnt0 and Gnt1 are never high together. Both are forced 0 while Reset is high.
- Accept (ReqN & GntN at an edge) has these effects:
  - `last` <= N.
  - Addr <= AddrN and nCS <= 0.
  - For writes: WData <= WDataN, nWE <= 0, nOE <= 1.
  - For reads: nWE <= 1, nOE <= 0, and the read tag shift register records client N.
- Edge with no accept:
  - nCS, nOE and nWE go to 1.
  - Addr and WData hold their last values.
- Read return: the tag is pipelined 2 stages. RValidN pulses for exactly one cycle, 2 cycles after the accept edge. RDataOut = RData.
- Back-to-back accepts are legal every cycle, so throughput is 1 command/cycle.
- Command ordering is preserved. A read accepted the cycle after a write to the same address returns the new data.
- Client rule: ReqN, WeN, AddrN and WDataN are held stable while ReqN is high and GntN is low. A client may keep ReqN high after an accept to issue the next command.
- Reset values:
  - nCS = nOE = nWE = 1.
  - Addr = 0, WData = 0.
  - RValid0 = RValid1 = 0.
  - Read tag pipeline empty.
  - `last` = 1, so client 0 wins the first contention.
- Reset mid-operation: all in-flight reads are discarded. No RValid is produced for commands accepted before or during reset.

## Timing
- Cycle N: ReqN & GntN, accepted at the end-of-N edge.
- Cycle N+1: SRAM command on the pins. SRAM samples it at the end-of-N+1 edge.
- Cycle N+2: for a read, RData is valid, RValidN = 1 and RDataOut is valid.
- Write completes at the end-of-N+1 edge.
- Grant is a combinational path from Req to Gnt, with no state on that path.
- Contention: grants alternate 0,1,0,1… on consecutive cycles with no idle cycles.

## Configuration
- SRAM_ARB_FIXED_PRIO_EN
  - Defined: client 0 always wins contention. The `last` pointer is not implemented. Client 1 is granted only when Req0 = 0.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset check: assert Reset mid-run, then release. Required response: nCS = nOE = nWE = 1, Addr = 0, WData = 0, RValid0/1 = 0, Gnt0/1 = 0 during reset.
- Write/read, client 0: write 0xA5A5 to address 5 (accept at cycle T), then read address 5 (accept at T+1). Required response at T+2: nCS = 0, nWE = 1, nOE = 0. Required response at T+3: RValid0 = 1, RDataOut = 0xA5A5, RValid1 = 0.
- Contention: Req0 and Req1 held high for 6 cycles after reset. Required response: Gnt pattern 0,1,0,1,0,1.
- Client 1 streaming: 4 back-to-back reads of addresses 0..3, preloaded with 0x10..0x13. Required response: Gnt1 high 4 consecutive cycles; RValid1 high 4 consecutive cycles starting 2 cycles after the first accept, with data 0x10,0x11,0x12,0x13.
- Reset during an in-flight read: accept a read at cycle T, assert Reset during T+1. Required response: no RValid pulse in any later cycle.
- SRAM_ARB_FIXED_PRIO_EN defined: Req0 and Req1 both high for 5 cycles. Required response: Gnt0 high on all 5 cycles and Gnt1 never high. Dropping Req0 gives Gnt1 the next cycle.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: client command/grant/read-return signals plus the SRAM pin bundle.
// slave is the arbiter's view; master is the clients-plus-SRAM environment.
interface sram_arbiter_if #(
  parameter int ADDR_SIZE = 6,
  parameter int DATA_SIZE = 16
);
  logic                 i_req0, i_req1;
  logic                 i_we0, i_we1;
  logic [ADDR_SIZE-1:0] i_addr0, i_addr1;
  logic [DATA_SIZE-1:0] i_wdata0, i_wdata1;
  logic                 o_gnt0, o_gnt1;
  logic                 o_rvalid0, o_rvalid1;
  logic [DATA_SIZE-1:0] o_rdata_out;
  logic [ADDR_SIZE-1:0] o_addr;
  logic [DATA_SIZE-1:0] o_wdata;
  logic [DATA_SIZE-1:0] i_rdata;
  logic                 o_ncs, o_noe, o_nwe;
  modport slave (
    input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1, i_rdata,
    output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata_out, o_addr, o_wdata, o_ncs, o_noe, o_nwe
  );
  modport master (
    output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1, i_rdata,
    input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata_out, o_addr, o_wdata, o_ncs, o_noe, o_nwe
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-client round-robin arbiter onto a single-port SRAM with tagged read return.
// Define SRAM_ARB_FIXED_PRIO_EN to make client 0 always win contention (no round-robin pointer).
module sram_arbiter #(
  parameter int ADDR_SIZE = 6,
  parameter int DATA_SIZE = 16
) (
  input logic          i_clk,
  input logic          i_rst,
  sram_arbiter_if.slave bus
);
  logic                 w_gnt0, w_gnt1, w_acc, w_sel, w_we;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [DATA_SIZE-1:0] w_wdata;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [DATA_SIZE-1:0] r_wdata;
  logic                 r_ncs, r_noe, r_nwe;
  logic                 r_t1_v, r_t1_c, r_t2_v, r_t2_c;
`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign w_gnt0 = !i_rst && bus.i_req0;
`else
  logic r_last;
  assign w_gnt0 = !i_rst && bus.i_req0 && (!bus.i_req1 || r_last);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_last <= 1'b1;
    else if (w_acc) r_last <= w_sel;
`endif
  assign w_gnt1  = !i_rst && bus.i_req1 && !w_gnt0;
  assign w_acc   = w_gnt0 || w_gnt1;
  assign w_sel   = w_gnt1;
  assign w_we    = w_sel ? bus.i_we1    : bus.i_we0;
  assign w_addr  = w_sel ? bus.i_addr1  : bus.i_addr0;
  assign w_wdata = w_sel ? bus.i_wdata1 : bus.i_wdata0;
  // Tag stage 1 lines up with the SRAM command cycle, stage 2 with the returned data.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_ncs   <= 1'b1;
      r_noe   <= 1'b1;
      r_nwe   <= 1'b1;
      r_t1_v  <= 1'b0;
      r_t1_c  <= 1'b0;
      r_t2_v  <= 1'b0;
      r_t2_c  <= 1'b0;
    end else begin
      r_ncs  <= !w_acc;
      r_nwe  <= !(w_acc && w_we);
      r_noe  <= !(w_acc && !w_we);
      if (w_acc) r_addr <= w_addr;
      if (w_acc && w_we) r_wdata <= w_wdata;
      r_t1_v <= w_acc && !w_we;
      r_t1_c <= w_sel;
      r_t2_v <= r_t1_v;
      r_t2_c <= r_t1_c;
    end
  assign bus.o_gnt0      = w_gnt0;
  assign bus.o_gnt1      = w_gnt1;
  assign bus.o_rvalid0   = r_t2_v && !r_t2_c;
  assign bus.o_rvalid1   = r_t2_v && r_t2_c;
  assign bus.o_rdata_out = bus.i_rdata;
  assign bus.o_addr      = r_addr;
  assign bus.o_wdata     = r_wdata;
  assign bus.o_ncs       = r_ncs;
  assign bus.o_noe       = r_noe;
  assign bus.o_nwe       = r_nwe;
endmodule
